// File: rtl/elevator_pkg.sv
// Shared types and scan-search helpers for the elevator scheduler.
// Latency: pure combinational functions, no state.
// Backpressure: none; helpers are evaluated every cycle by their callers.
package elevator_pkg;

    // Upper bound on served floors; search helpers operate on this width.
    localparam int MAX_FLOORS = 16;
    // Dwell counter width, enough for DWELL_CYCLES up to 255.
    localparam int DWELL_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        DECIDE,
        MOVE,
        DOOR
    } state_t;

    // Result of a scan search: whether a call was found and at which floor.
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } scan_t;

    // Floor index width; a one-floor build still needs one bit.
    function automatic int floor_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Lowest pending floor strictly above 'floor' (pass -1 for "lowest overall").
    function automatic scan_t next_above(input logic [MAX_FLOORS-1:0] pend, input int floor);
        scan_t r;
        r = '0;
        for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
            if (pend[i] && (i > floor)) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

    // Highest pending floor strictly below 'floor'.
    function automatic scan_t next_below(input logic [MAX_FLOORS-1:0] pend, input int floor);
        scan_t r;
        r = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (pend[i] && (i < floor)) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Signal bundle between the button/LED front end, movement controller and scheduler.
// Latency: wires only.
// Backpressure: none; the movement controller paces the scheduler through arrived.
interface elevator_scheduler_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 3,
    parameter int FLOOR_W    = floor_w(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] req;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  arrived;
    logic [NUM_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  move_req;
    logic                  dir_up;
    logic                  door_open;

    // Environment side: buttons and movement controller.
    modport master (
        output req, cur_floor, arrived,
        input  pending, target_floor, move_req, dir_up, door_open
    );

    // Scheduler side.
    modport slave (
        input  req, cur_floor, arrived,
        output pending, target_floor, move_req, dir_up, door_open
    );
endinterface

// File: rtl/elevator_scheduler_dwell_timer.sv
// Door dwell timer: load/reload to DWELL_CYCLES-1, count down, flag zero.
// Latency: done_o reflects the registered count, one edge after load/decrement.
// Backpressure: load_i overrides dec_i, so a held door restarts the full dwell.
module dwell_timer
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Next count: reload has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = DWELL_W'(DWELL_CYCLES - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car-call scheduler: latches calls, picks next target, sequences move/door phases.
// Latency: call sampled at E0 with car idle elsewhere -> move_req high after E2.
// Backpressure: waits on arrived at target; door press at current floor extends dwell.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS   = 3,
    parameter  int DWELL_CYCLES = 4,
    localparam int FLOOR_W      = floor_w(NUM_FLOORS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_scheduler_if.slave  bus
);
    state_t                 state_q;
    logic [NUM_FLOORS-1:0]  pending_q;
    logic [NUM_FLOORS-1:0]  pending_d;
    logic [FLOOR_W-1:0]     target_q;
    logic                   move_req_q;
    logic                   dir_up_q;
    logic                   door_open_q;

    logic [NUM_FLOORS-1:0]  cur_oh;
    logic [NUM_FLOORS-1:0]  tgt_oh;
    logic [MAX_FLOORS-1:0]  pend_ext;
    int                     cur_int;
    logic                   cur_valid;
    logic                   pend_here;
    logic                   req_here;
    logic                   hold;
    logic                   at_target;
    logic                   enter_door;
    logic                   dwell_done;
    scan_t                  above;
    scan_t                  below;
    scan_t                  lowest;

    logic                   dec_found;
    logic [3:0]             dec_idx;
    logic                   dec_up;
    logic                   rt_vld;
    logic [3:0]             rt_idx;

    // Out-of-range cur_floor shifts the one-hot to zero, so it matches no floor.
    assign cur_oh    = NUM_FLOORS'(1) << bus.cur_floor;
    assign tgt_oh    = NUM_FLOORS'(1) << target_q;
    assign pend_ext  = MAX_FLOORS'(pending_q);
    assign cur_int   = int'(bus.cur_floor);
    assign cur_valid = (cur_int < NUM_FLOORS);
    assign pend_here = |(pending_q & cur_oh);
    assign req_here  = |(bus.req & cur_oh);
    assign hold      = (state_q == DOOR) && req_here;
    assign at_target = bus.arrived && (bus.cur_floor == target_q);
    assign enter_door = ((state_q == IDLE) && pend_here) || ((state_q == MOVE) && at_target);

    assign above  = next_above(pend_ext, cur_int);
    assign below  = next_below(pend_ext, cur_int);
    assign lowest = next_above(pend_ext, -1);

    // Call latch: new presses set, service clears (clear wins), door-hold presses are swallowed.
    always_comb begin
        logic [NUM_FLOORS-1:0] set_mask;
        logic [NUM_FLOORS-1:0] clr_mask;
        set_mask = bus.req & ~(hold ? cur_oh : '0);
        clr_mask = '0;
        if ((state_q == IDLE) && pend_here) begin
            clr_mask = cur_oh;
        end else if ((state_q == MOVE) && at_target) begin
            clr_mask = tgt_oh;
        end
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    // SCAN choice: continue in the current direction, else reverse; unknown floor falls to lowest call.
    always_comb begin
        dec_found = 1'b0;
        dec_idx   = '0;
        dec_up    = dir_up_q;
        if (!cur_valid) begin
            dec_found = lowest.found;
            dec_idx   = lowest.idx;
            dec_up    = 1'b0;
        end else if (dir_up_q) begin
            if (above.found) begin
                dec_found = 1'b1;
                dec_idx   = above.idx;
            end else if (below.found) begin
                dec_found = 1'b1;
                dec_idx   = below.idx;
                dec_up    = 1'b0;
            end
        end else begin
            if (below.found) begin
                dec_found = 1'b1;
                dec_idx   = below.idx;
            end else if (above.found) begin
                dec_found = 1'b1;
                dec_idx   = above.idx;
                dec_up    = 1'b1;
            end
        end
    end

    // Re-target while moving: nearest call strictly between the car and its target.
    always_comb begin
        if (dir_up_q) begin
            rt_vld = above.found && (int'(above.idx) < int'(target_q));
            rt_idx = above.idx;
        end else begin
            rt_vld = below.found && (int'(below.idx) > int'(target_q));
            rt_idx = below.idx;
        end
    end

    // Outstanding-call register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Phase sequencer with registered target, direction, move and door outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            move_req_q  <= 1'b0;
            dir_up_q    <= 1'b1;
            door_open_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_here) begin
                        state_q     <= DOOR;
                        door_open_q <= 1'b1;
                    end else if (|pending_q) begin
                        state_q <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (dec_found) begin
                        state_q    <= MOVE;
                        target_q   <= FLOOR_W'(dec_idx);
                        dir_up_q   <= dec_up;
                        move_req_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MOVE: begin
                    if (at_target) begin
                        state_q     <= DOOR;
                        move_req_q  <= 1'b0;
                        door_open_q <= 1'b1;
                    end else if (rt_vld) begin
                        target_q <= FLOOR_W'(rt_idx);
                    end
                end
                DOOR: begin
                    if (!hold && dwell_done) begin
                        state_q     <= (|pending_q) ? DECIDE : IDLE;
                        door_open_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (enter_door || hold),
        .dec_i  (state_q == DOOR),
        .done_o (dwell_done)
    );

    assign bus.pending      = pending_q;
    assign bus.target_floor = target_q;
    assign bus.move_req     = move_req_q;
    assign bus.dir_up       = dir_up_q;
    assign bus.door_open    = door_open_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus randomized car traffic.
// Latency: expected outputs are queued at each rising edge and checked on the falling edge.
// Backpressure: a car emulator answers move_req with floor steps and arrived pulses.
module tb_elevator_scheduler;
    localparam int NF = 3;
    localparam int DW = 4;
    localparam int FW = $clog2(NF);

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    elevator_scheduler_if #(.NUM_FLOORS(NF)) bus ();

    elevator_scheduler #(
        .NUM_FLOORS   (NF),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NF-1:0] pend;
        int            tgt;
        bit            mv;
        bit            up;
        bit            door;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: call set, car intent, and the absolute cycle when the door closes.
    bit mp[NF];
    int m_tgt;
    bit m_move, m_dec, m_door, m_up;
    int m_close;
    int m_cyc;

    task automatic m_reset();
        for (int i = 0; i < NF; i++) mp[i] = 1'b0;
        m_tgt = 0; m_move = 0; m_dec = 0; m_door = 0; m_up = 1;
    endtask

    task automatic m_step(input logic [NF-1:0] r, input int cf, input bit arr);
        bit old[NF];
        bit clr[NF];
        bit blk[NF];
        int cnt;
        int f;
        bit found;
        cnt = 0; f = 0; found = 0;
        for (int i = 0; i < NF; i++) begin
            old[i] = mp[i]; clr[i] = 0; blk[i] = 0; cnt += int'(old[i]);
        end
        if (m_door) begin
            if (cf < NF && r[cf]) begin
                m_close = m_cyc + DW;
                blk[cf] = 1;
            end else if (m_cyc == m_close) begin
                m_door = 0;
                m_dec  = (cnt > 0);
            end
        end else if (m_dec) begin
            m_dec = 0;
            if (cf >= NF) begin
                for (int i = NF - 1; i >= 0; i--) if (old[i]) begin f = i; found = 1; end
                if (found) m_up = 0;
            end else if (m_up) begin
                for (int i = NF - 1; i > cf; i--) if (old[i]) begin f = i; found = 1; end
                if (!found) begin
                    for (int i = 0; i < cf; i++) if (old[i]) begin f = i; found = 1; end
                    if (found) m_up = 0;
                end
            end else begin
                for (int i = 0; i < cf; i++) if (old[i]) begin f = i; found = 1; end
                if (!found) begin
                    for (int i = NF - 1; i > cf; i--) if (old[i]) begin f = i; found = 1; end
                    if (found) m_up = 1;
                end
            end
            if (found) begin m_tgt = f; m_move = 1; end
        end else if (m_move) begin
            if (arr && cf == m_tgt) begin
                m_move = 0; m_door = 1; clr[m_tgt] = 1; m_close = m_cyc + DW;
            end else if (m_up) begin
                for (int i = m_tgt - 1; i > cf; i--) if (old[i]) begin f = i; found = 1; end
                if (found) m_tgt = f;
            end else begin
                for (int i = m_tgt + 1; i < cf && i < NF; i++) if (old[i]) begin f = i; found = 1; end
                if (found) m_tgt = f;
            end
        end else begin
            if (cf < NF && old[cf]) begin
                m_door = 1; clr[cf] = 1; m_close = m_cyc + DW;
            end else if (cnt > 0) begin
                m_dec = 1;
            end
        end
        for (int i = 0; i < NF; i++) mp[i] = (old[i] | (r[i] & !blk[i])) & !clr[i];
        m_cyc++;
    endtask

    // Model advances on each rising edge and queues the outputs the DUT must show.
    initial begin : model
        exp_t e;
        m_reset();
        m_cyc = 0;
        m_close = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset();
            else m_step(bus.req, int'(bus.cur_floor), bus.arrived);
            for (int i = 0; i < NF; i++) e.pend[i] = mp[i];
            e.tgt = m_tgt; e.mv = m_move; e.up = m_up; e.door = m_door;
            exp_q.push_back(e);
        end
    end

    // Monitor: pop one expectation per cycle and compare all outputs.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.pending !== e.pend || int'(bus.target_floor) != e.tgt ||
                    bus.move_req !== e.mv || bus.dir_up !== e.up || bus.door_open !== e.door) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t pend=%b/%b tgt=%0d/%0d move=%b/%b up=%b/%b door=%b/%b (got/want)",
                             $time, bus.pending, e.pend, bus.target_floor, e.tgt, bus.move_req, e.mv,
                             bus.dir_up, e.up, bus.door_open, e.door);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Counts cycles the door stays open from now; an open door past the bound is a failure.
    task automatic door_len(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.door_open) break;
            n++;
            tick();
        end
        if (n >= 40) chk({nm, "_timeout"}, 32'(bus.door_open), 0);
    endtask

    task automatic arrive_at(input int fl);
        bus.cur_floor = FW'(fl);
        bus.arrived   = 1'b1;
        tick();
        bus.arrived   = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stim
        int n;
        total = 0; bad = 0;
        rst_n = 1'b0;
        bus.req = '0; bus.cur_floor = '0; bus.arrived = 1'b0;
        tick(); tick();
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_dir_up", 32'(bus.dir_up), 1);
        chk("rst_move", 32'(bus.move_req), 0);
        #2 rst_n = 1'b1;
        tick();

        // Single call to the top floor from the bottom, with a stray arrival en route.
        bus.req = 3'b100; tick(); bus.req = '0;
        chk("t1_pending", 32'(bus.pending), 3'b100);
        tick();
        chk("t1_decide_nomove", 32'(bus.move_req), 0);
        tick();
        chk("t1_target", 32'(bus.target_floor), 2);
        chk("t1_dir", 32'(bus.dir_up), 1);
        chk("t1_move", 32'(bus.move_req), 1);
        bus.cur_floor = 1; tick();
        arrive_at(1);
        chk("t5_stray_door", 32'(bus.door_open), 0);
        chk("t5_stray_move", 32'(bus.move_req), 1);
        arrive_at(2);
        chk("t1_door", 32'(bus.door_open), 1);
        chk("t1_served", 32'(bus.pending), 0);
        door_len("t1_dwell", n);
        chk("t1_dwell", 32'(n), DW);
        tick();
        chk("t1_idle_move", 32'(bus.move_req), 0);

        // Car at floor 1 heading up with calls above and below.
        bus.cur_floor = 1; bus.req = 3'b101; tick(); bus.req = '0;
        tick(); tick();
        chk("t2_first_tgt", 32'(bus.target_floor), 2);
        chk("t2_first_dir", 32'(bus.dir_up), 1);
        arrive_at(2);
        chk("t2_left", 32'(bus.pending), 3'b001);
        door_len("t2_dwell_a", n);
        tick();
        chk("t2_rev_tgt", 32'(bus.target_floor), 0);
        chk("t2_rev_dir", 32'(bus.dir_up), 0);
        bus.cur_floor = 1; tick();
        arrive_at(0);
        door_len("t2_dwell_b", n);
        tick();
        chk("t2_dir_persist", 32'(bus.dir_up), 0);

        // Asynchronous reset while the door is open with calls pending.
        bus.cur_floor = 2; bus.req = 3'b111; tick(); bus.req = '0;
        tick();
        chk("t6_door", 32'(bus.door_open), 1);
        chk("t6_pending", 32'(bus.pending), 3'b011);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_pend", 32'(bus.pending), 0);
        chk("t6_async_door", 32'(bus.door_open), 0);
        chk("t6_async_dir", 32'(bus.dir_up), 1);
        tick(); tick();
        #2 rst_n = 1'b1;
        tick(); tick();
        chk("t6_after_move", 32'(bus.move_req), 0);
        chk("t6_after_door", 32'(bus.door_open), 0);

        // Re-target onto an intermediate call while travelling 0 -> 2.
        bus.cur_floor = 0; bus.req = 3'b100; tick(); bus.req = '0;
        tick(); tick();
        chk("t3_tgt", 32'(bus.target_floor), 2);
        bus.req = 3'b010; tick(); bus.req = '0;
        tick();
        chk("t3_retarget", 32'(bus.target_floor), 1);
        arrive_at(1);
        door_len("t3_dwell_a", n);
        tick();
        chk("t3_resume", 32'(bus.target_floor), 2);
        arrive_at(2);
        door_len("t3_dwell_b", n);
        tick();

        // Unknown floor (beyond top): lowest call, scanning down.
        bus.cur_floor = 3; bus.req = 3'b001; tick(); bus.req = '0;
        tick(); tick();
        chk("t7_tgt", 32'(bus.target_floor), 0);
        chk("t7_dir", 32'(bus.dir_up), 0);
        bus.cur_floor = 2; tick();
        bus.cur_floor = 1; tick();
        arrive_at(0);
        door_len("t7_dwell", n);
        tick();

        // Call at current floor while idle, then a hold press mid-dwell.
        bus.req = 3'b001; tick(); bus.req = '0;
        tick();
        chk("t4_door", 32'(bus.door_open), 1);
        chk("t4_nomove", 32'(bus.move_req), 0);
        tick(); tick();
        bus.req = 3'b001; tick(); bus.req = '0;
        chk("t4_hold_nopend", 32'(bus.pending), 0);
        door_len("t4_hold", n);
        chk("t4_hold_len", 32'(n), DW);
        tick();

        // Randomized traffic with a car emulator, stray arrivals and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            bus.req = '0;
            for (int i = 0; i < NF; i++) if ($urandom_range(0, 11) == 0) bus.req[i] = 1'b1;
            bus.arrived = 1'b0;
            if (m_move) begin
                if (int'(bus.cur_floor) == m_tgt) begin
                    if ($urandom_range(0, 1) == 1) bus.arrived = 1'b1;
                end else if ($urandom_range(0, 2) == 0) begin
                    if (int'(bus.cur_floor) < m_tgt) bus.cur_floor = bus.cur_floor + FW'(1);
                    else bus.cur_floor = bus.cur_floor - FW'(1);
                end
            end else if (!m_door && $urandom_range(0, 15) == 0) begin
                bus.cur_floor = FW'($urandom_range(0, (1 << FW) - 1));
            end
            if ($urandom_range(0, 9) == 0) bus.arrived = 1'b1;
            if (m_door && int'(bus.cur_floor) < NF && $urandom_range(0, 7) == 0) bus.req[bus.cur_floor] = 1'b1;
            if (k % 700 == 350) begin
                #2 rst_n = 1'b0;
                tick(); tick();
                #2 rst_n = 1'b1;
            end
            tick();
        end
        bus.req = '0; bus.arrived = 1'b0;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Parametrised N-floor car-call scheduler. Latches floor requests and chooses the next target floor with a SCAN (elevator) policy: keep travelling in the current direction while requests lie ahead, otherwise reverse.
- Sequences move, arrive and door-dwell phases through a registered state machine and a dwell timer.
- Sits between the button/LED front end and the movement controller. The movement controller reports cur_floor and arrived; this block drives target_floor and move_req.

Parameters:
- NUM_FLOORS, 3, number of served floors (2..16); floor 0 is the lowest.
- FLOOR_W, $clog2(NUM_FLOORS), floor index width (derived; not overridden).
- DWELL_CYCLES, 4, clock cycles the door stays open (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_FLOORS  call buttons, one bit per floor; a level high for one or more cycles registers a call.
- cur_floor  in  FLOOR_W  floor the car is at or passing, from the movement controller.
- arrived  in  1  1-cycle pulse: car has stopped at cur_floor.
- pending  out  NUM_FLOORS  latched outstanding calls (drives floor LEDs).
- target_floor  out  FLOOR_W  current destination; valid while move_req=1.
- move_req  out  1  car must travel toward target_floor.
- dir_up  out  1  1 = scanning upward, 0 = downward.
- door_open  out  1  door held open.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pending=0, target_floor=0, move_req=0, dir_up=1, door_open=0, dwell counter=0.
- Request latch: pending[i] is set on the edge after req[i] is sampled high. A request already pending has no further effect. Clearing happens only on service (see DOOR). If a set and a clear hit the same bit in one cycle, the clear wins.
- State IDLE:
  - If pending[cur_floor]=1: go to DOOR and clear that bit.
  - Else if pending≠0: go to DECIDE.
  - Else remain in IDLE.
- State DECIDE (exactly 1 cycle):
  - With dir_up=1: target = lowest pending floor > cur_floor. If there is none, dir_up←0 and target = highest pending floor < cur_floor.
  - With dir_up=0: the mirror rule (highest pending floor below; else flip and take lowest pending floor above).
  - Register target_floor and go to MOVE.
  - Latency: a request sampled at edge E0 (car idle, other floor) gives move_req=1 after edge E2.
- State MOVE: move_req=1.
  - Re-targeting: if a new call is pending strictly between cur_floor and target_floor in the travel direction, target_floor updates to the nearest such floor on the next edge.
  - On arrived with cur_floor==target_floor: go to DOOR, clear pending[target_floor], move_req←0.
  - arrived at any other floor is ignored.
- State DOOR: door_open=1 and the dwell counter is loaded with DWELL_CYCLES-1.
  - Each cycle the counter decrements.
  - A req for cur_floor while in DOOR reloads the counter (hold-door) and does not set pending.
  - At count 0: go to DECIDE if pending≠0, else IDLE; door_open←0 on that same edge.
- Direction persists across IDLE, so a later call resumes SCAN in the last direction.
- Boundaries:
  - At the top floor only the downward search can succeed; the bottom floor mirrors this.
  - cur_floor ≥ NUM_FLOORS (non-power-of-2 N) matches no floor. DECIDE then falls back to the lowest pending floor with dir_up=0.
- Reset asserted mid-MOVE or mid-DOOR drops all calls and outputs immediately (async).

Decomposition:
- elevator_pkg holds:
  - the state enum (IDLE, DECIDE, MOVE, DOOR);
  - the FLOOR_W helper function;
  - the DWELL width constant;
  - the scan-search functions next_above(pending, floor) and next_below(pending, floor), each returning a found flag and an index.
- One sub-module: dwell_timer (load, hold-reload, decrement, done flag), parametrised by DWELL_CYCLES.

Test Plan:
- Reset, then req=3'b100 pulse with cur_floor=0 → pending=100; DECIDE; target_floor=2, dir_up=1, move_req=1 two edges after sampling. arrived at floor 2 → door_open=1 for exactly 4 cycles, pending=000, back to IDLE.
- Car at floor 1, dir_up=1, pending={0,2} → target 2 first. After service, DECIDE flips dir_up=0 and targets 0.
- NUM_FLOORS=8, moving 0→6, req[3] arrives while cur_floor=1 → target_floor switches to 3. After that door cycle the car proceeds to 6.
- req for cur_floor while IDLE → door_open next cycle, move_req stays 0. A repeated press during DOOR extends open time by a full DWELL_CYCLES from the press.
- arrived pulse at a non-target floor (floor 1 while heading to 2) → no door, state stays MOVE.
- rst_n low mid-DOOR with pending=011 → all outputs 0 and dir_up=1 asynchronously. After release the block is IDLE with no movement.
